enemy_hit_detector: RTL
=======================

ENEMY_HIT_DETECTOR -- requirements
Module: enemy_hit_detector

Interface
REQ-001 SHALL have parameter OBJECT_WIDTH_X, default 32, enemy sprite width in pixels.
REQ-002 SHALL have parameter OBJECT_HIGHT_Y, default 32, enemy sprite height in pixels.
REQ-003 SHALL have parameter EDGE_W, default 4, edge-zone thickness in pixels.
REQ-004 SHALL have parameter HIT_THRESHOLD, default 8, overlapping pixels on one edge per frame needed to report.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port resetN, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port startOfFrame, input, 1, one-cycle pulse at frame start.
REQ-008 SHALL have port enemyDR, input, 1, enemy drawing request for the current pixel.
REQ-009 SHALL have port obstacleDR, input, 1, wall/brick/bomb drawing request for the current pixel.
REQ-010 SHALL have port offsetX, input, 11, current pixel X minus enemy topLeftX, valid when enemyDR=1.
REQ-011 SHALL have port offsetY, input, 11, current pixel Y minus enemy topLeftY, valid when enemyDR=1.
REQ-012 SHALL have port collision, output, 1, one-cycle pulse when an edge hit is reported.
REQ-013 SHALL have port HitEdgeCode, output, 4, reported edge: TOP 4'b0100, RIGHT 4'b0010, LEFT 4'b1000, BOTTOM 4'b0001, none 4'b0000.

Function
REQ-014 SHALL classify an overlap pixel (enemyDR && obstacleDR) into zones: LEFT offsetX<EDGE_W; RIGHT offsetX>=OBJECT_WIDTH_X-EDGE_W; TOP offsetY<EDGE_W; BOTTOM offsetY>=OBJECT_HIGHT_Y-EDGE_W.
REQ-015 SHALL ignore overlap pixels in no zone (sprite interior).
REQ-016 SHALL keep four 10-bit saturating per-edge counters, one per zone, each incremented by 1 per classified overlap pixel.
REQ-017 SHALL implement FSM states IDLE_ST, ARMED_ST, REPORT_ST, DONE_ST.
REQ-018 SHALL transition IDLE_ST->ARMED_ST on first startOfFrame after reset, clearing all counters.
REQ-019 SHALL, in ARMED_ST, move to REPORT_ST in the cycle after any counter's registered value reaches HIT_THRESHOLD.
REQ-020 SHALL assert collision=1 for exactly the single REPORT_ST cycle, then go to DONE_ST.
REQ-021 SHALL load HitEdgeCode on entering REPORT_ST and hold it stable until the next startOfFrame.
REQ-022 SHALL, when several counters reach the threshold in the same cycle, report priority TOP > BOTTOM > LEFT > RIGHT.
REQ-023 SHALL report at most one collision per frame; DONE_ST ignores further overlaps.
REQ-024 SHALL, on startOfFrame in ARMED_ST, REPORT_ST or DONE_ST: clear counters, set HitEdgeCode=4'b0000, enter ARMED_ST.
REQ-025 SHALL give startOfFrame priority over a same-cycle overlap pixel; that pixel is not counted.
REQ-026 SHALL give startOfFrame priority over a pending report; a REPORT_ST cycle coinciding with startOfFrame still drives collision=1, then enters ARMED_ST.
REQ-027 SHALL have overlap-pixel-to-collision latency of exactly 2 clk cycles (counter update, then REPORT_ST).
REQ-028 SHALL saturate counters at 1023 with no wrap-around.
REQ-029 SHALL compare offsets unsigned; offsets >= sprite size (enemyDR glitch) SHALL be ignored.

Reset
REQ-030 SHALL on resetN=0 force IDLE_ST, counters 0, collision=0, HitEdgeCode=4'b0000, asynchronously.
REQ-031 SHALL, on reset mid-frame, discard all counts; no collision until after the next startOfFrame.

Configuration
REQ-032 SHALL provide macro ENEMY_HIT_CORNER_EN: when defined, a pixel in two zones (corner) increments both counters; when undefined, corner pixels are ignored entirely.

Verification
REQ-033 SHALL pass: SOF, then 8 overlap pixels at offsetX=31, offsetY=10..17 -> collision pulse 2 cycles after 8th pixel, HitEdgeCode=4'b0010 held until next SOF.
REQ-034 SHALL pass: 7 overlap pixels at offsetY=0 in one frame, SOF, 7 more -> no collision in either frame.
REQ-035 SHALL pass: 20 pixels on LEFT edge (offsetX=1) -> exactly one collision pulse, code 4'b1000; subsequent pixels ignored.
REQ-036 SHALL pass: corner pixels offsetX=0, offsetY=0 x8 -> with ENEMY_HIT_CORNER_EN, collision with code 4'b0100 (TOP priority); without, no collision.
REQ-037 SHALL pass: resetN low after 6 BOTTOM pixels, release, 2 more pixels before SOF -> no collision; HitEdgeCode=0.
REQ-038 SHALL pass: overlap pixel coinciding with startOfFrame -> not counted; counter reads 0 next cycle.

Source files
------------

// File: rtl/enemy_hit_detector.sv
// Enemy edge-hit detector.
// Counts enemy/obstacle overlap pixels per sprite edge zone within a frame and
// reports the first edge to reach HIT_THRESHOLD as a one-cycle collision pulse.
// Optional build macro: ENEMY_HIT_CORNER_EN -- corner pixels (two zones) feed
// both edge counters; without it, corner pixels are ignored.
module enemy_hit_detector #(
    parameter int OBJECT_WIDTH_X = 32,
    parameter int OBJECT_HIGHT_Y = 32,
    parameter int EDGE_W         = 4,
    parameter int HIT_THRESHOLD  = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enemyDR,
    input  logic        obstacleDR,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    output logic        collision,
    output logic [3:0]  HitEdgeCode
);

    localparam logic [1:0] IDLE_ST   = 2'd0;
    localparam logic [1:0] ARMED_ST  = 2'd1;
    localparam logic [1:0] REPORT_ST = 2'd2;
    localparam logic [1:0] DONE_ST   = 2'd3;

    localparam logic [10:0] SIZE_X     = 11'(OBJECT_WIDTH_X);
    localparam logic [10:0] SIZE_Y     = 11'(OBJECT_HIGHT_Y);
    localparam logic [10:0] EDGE       = 11'(EDGE_W);
    localparam logic [10:0] RIGHT_LIM  = 11'(OBJECT_WIDTH_X - EDGE_W);
    localparam logic [10:0] BOTTOM_LIM = 11'(OBJECT_HIGHT_Y - EDGE_W);
    localparam logic [9:0]  CNT_MAX    = '1;
    localparam logic [9:0]  THRESH     = 10'(HIT_THRESHOLD);

    // Zone/counter bit positions match the HitEdgeCode encoding:
    // [3]=LEFT, [2]=TOP, [1]=RIGHT, [0]=BOTTOM.
    logic [1:0] state;
    logic [9:0] cnt [4];
    logic       in_sprite;
    logic [3:0] zone;
    logic [3:0] inc;
    logic [3:0] reached;
    logic [3:0] next_code;

    // Classify the current overlap pixel into edge zones.
    always_comb begin
        in_sprite = (offsetX < SIZE_X) && (offsetY < SIZE_Y);
        zone      = '0;
        if (enemyDR && obstacleDR && in_sprite) begin
            zone = {offsetX < EDGE, offsetY < EDGE,
                    offsetX >= RIGHT_LIM, offsetY >= BOTTOM_LIM};
        end
`ifdef ENEMY_HIT_CORNER_EN
        inc = zone;
`else
        inc = ($countones(zone) == 1) ? zone : '0;
`endif
    end

    // Threshold detection with fixed edge priority TOP > BOTTOM > LEFT > RIGHT.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            reached[i] = (cnt[i] >= THRESH);
        end
        next_code = '0;
        if (reached[2])      next_code = 4'b0100;
        else if (reached[0]) next_code = 4'b0001;
        else if (reached[3]) next_code = 4'b1000;
        else if (reached[1]) next_code = 4'b0010;
        collision = (state == REPORT_ST);
    end

    // Per-edge saturating counters; cleared on frame start, count only while armed.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (startOfFrame) begin
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (state == ARMED_ST) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (inc[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 10'd1;
            end
        end
    end

    // Frame FSM: arm on frame start, report once per frame, then hold the code.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE_ST;
            HitEdgeCode <= '0;
        end else if (startOfFrame) begin
            state       <= ARMED_ST;
            HitEdgeCode <= '0;
        end else begin
            case (state)
                ARMED_ST: begin
                    if (|reached) begin
                        state       <= REPORT_ST;
                        HitEdgeCode <= next_code;
                    end
                end
                REPORT_ST: state <= DONE_ST;
                default:   state <= state;
            endcase
        end
    end

endmodule
